// File: rtl/bool_network_engine_if.sv
// Host-side bundle for the Boolean-network engine:
// rule-table config port, run control and per-round state stream.
interface bool_network_engine_if #(
  parameter int N_ELEM  = 64,
  parameter int N_RULES = 64,
  parameter int N_TERMS = 4,
  parameter int ROUND_W = 10
);
  localparam int RIDX_W = $clog2(N_RULES);
  localparam int TIDX_W = $clog2(N_TERMS);
  localparam int EIDX_W = $clog2(N_ELEM);

  logic              cfg_we;
  logic [RIDX_W-1:0] cfg_rule;
  logic [TIDX_W-1:0] cfg_term;
  logic [EIDX_W-1:0] cfg_target;
  logic              cfg_rule_en;
  logic              cfg_term_en;
  logic [N_ELEM-1:0] cfg_pos;
  logic [N_ELEM-1:0] cfg_neg;
  logic              cfg_err;

  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [ROUND_W-1:0] n_rounds;
  logic [N_ELEM-1:0]  init_state;
  logic [N_ELEM-1:0]  toggle_mask;
  logic [N_ELEM-1:0]  toggle_value;
  logic [ROUND_W-1:0] toggle_round;

  logic               busy;
  logic               done;
  logic               state_valid;
  logic [N_ELEM-1:0]  state_out;
  logic [ROUND_W-1:0] round_out;

  modport master (
    output cfg_we, cfg_rule, cfg_term, cfg_target,
    output cfg_rule_en, cfg_term_en, cfg_pos, cfg_neg,
    output start, abort, mode, n_rounds, init_state,
    output toggle_mask, toggle_value, toggle_round,
    input  cfg_err, busy, done, state_valid,
    input  state_out, round_out
  );

  modport slave (
    input  cfg_we, cfg_rule, cfg_term, cfg_target,
    input  cfg_rule_en, cfg_term_en, cfg_pos, cfg_neg,
    input  start, abort, mode, n_rounds, init_state,
    input  toggle_mask, toggle_value, toggle_round,
    output cfg_err, busy, done, state_valid,
    output state_out, round_out
  );
endinterface

// File: rtl/bool_network_engine.sv
// Run-time programmable Boolean-network engine: sum-of-products
// rules, sync / round-robin / LFSR-random update, forced inputs.
module bool_network_engine #(
  parameter int          N_ELEM    = 64,
  parameter int          N_RULES   = 64,
  parameter int          N_TERMS   = 4,
  parameter int          ROUND_W   = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                  clk,
  input logic                  reset,
  bool_network_engine_if.slave bus
);
  localparam int RIDX_W = $clog2(N_RULES);
  localparam int EIDX_W = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_e;

  fsm_e fsm_q, fsm_d;

  logic [N_ELEM-1:0]  pos_q [N_RULES][N_TERMS];
  logic [N_ELEM-1:0]  neg_q [N_RULES][N_TERMS];
  logic [N_TERMS-1:0] ten_q [N_RULES];
  logic [EIDX_W-1:0]  tgt_q [N_RULES];
  logic [N_RULES-1:0] ren_q;

  logic [1:0]         mode_q;
  logic [ROUND_W-1:0] nr_q;
  logic [ROUND_W-1:0] tr_q;
  logic [N_ELEM-1:0]  tm_q;
  logic [N_ELEM-1:0]  tv_q;
  logic [N_ELEM-1:0]  state_q;
  logic [ROUND_W-1:0] round_q;
  logic [RIDX_W-1:0]  rr_q;
  logic [15:0]        lfsr_q;
  logic               sv_q;
  logic               err_q;

  logic               idle;
  logic               seq_m;
  logic               rnd_m;
  logic [15:0]        lfsr_nx;
  logic [N_RULES-1:0] rval;
  logic [N_ELEM-1:0]  sync_nx;
  logic [RIDX_W-1:0]  sel;
  logic               sel_ok;
  logic [N_ELEM-1:0]  seq_nx;
  logic [N_ELEM-1:0]  upd;
  logic [N_ELEM-1:0]  frc;
  logic [N_ELEM-1:0]  f0;
  logic [N_ELEM-1:0]  nxt_f;
  logic               round_end;
  logic               last;

  assign idle  = (fsm_q == S_IDLE);
  assign rnd_m = (mode_q == 2'd2);
  assign seq_m = (mode_q == 2'd1) | rnd_m;

  assign lfsr_nx = {1'b0, lfsr_q[15:1]}
                 ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    rval = '0;
    for (int r = 0; r < N_RULES; r++) begin
      for (int t = 0; t < N_TERMS; t++) begin
        if (ten_q[r][t]
            && ((pos_q[r][t] & ~state_q) == '0)
            && ((neg_q[r][t] & state_q) == '0))
          rval[r] = 1'b1;
      end
    end
  end

  // Ascending scan: the highest rule index targeting an element wins.
  always_comb begin
    sync_nx = state_q;
    for (int r = 0; r < N_RULES; r++) begin
      if (ren_q[r])
        sync_nx[tgt_q[r]] = rval[r];
    end
  end

  always_comb begin
    sel    = rnd_m ? lfsr_q[RIDX_W-1:0] : rr_q;
    sel_ok = 1'b0;
    if (int'(sel) < N_RULES)
      sel_ok = ren_q[sel];
    seq_nx = state_q;
    if (sel_ok)
      seq_nx[tgt_q[sel]] = rval[sel];
  end

  assign upd       = seq_m ? seq_nx : sync_nx;
  assign frc       = (round_q >= tr_q) ? tm_q : '0;
  assign nxt_f     = (upd & ~frc) | (tv_q & frc);
  assign f0        = (bus.toggle_round == '0) ? bus.toggle_mask : '0;
  assign round_end = seq_m ? (rr_q == RIDX_W'(N_RULES - 1)) : 1'b1;
  assign last      = round_end && ((round_q + ROUND_W'(1)) == nr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:
        if (bus.start)
          fsm_d = (bus.n_rounds == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (bus.abort)   fsm_d = S_IDLE;
        else if (last)   fsm_d = S_DONE;
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (1'b1)
      (fsm_q == S_RUN):  bus.busy = 1'b1;
      (fsm_q == S_DONE): bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N_RULES; r++) begin
        for (int t = 0; t < N_TERMS; t++) begin
          pos_q[r][t] <= '0;
          neg_q[r][t] <= '0;
        end
        ten_q[r] <= '0;
        tgt_q[r] <= '0;
      end
      ren_q <= '0;
    end else if (bus.cfg_we && idle) begin
      pos_q[bus.cfg_rule][bus.cfg_term] <= bus.cfg_pos;
      neg_q[bus.cfg_rule][bus.cfg_term] <= bus.cfg_neg;
      ten_q[bus.cfg_rule][bus.cfg_term] <= bus.cfg_term_en;
      tgt_q[bus.cfg_rule]               <= bus.cfg_target;
      ren_q[bus.cfg_rule]               <= bus.cfg_rule_en;
    end
  end

  // Abort freezes state, round count and LFSR on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= '0;
      nr_q    <= '0;
      tr_q    <= '0;
      tm_q    <= '0;
      tv_q    <= '0;
      state_q <= '0;
      round_q <= '0;
      rr_q    <= '0;
      lfsr_q  <= LFSR_SEED;
      sv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sv_q  <= 1'b0;
      err_q <= bus.cfg_we & ~idle;
      unique case (fsm_q)
        S_IDLE:
          if (bus.start) begin
            mode_q  <= bus.mode;
            nr_q    <= bus.n_rounds;
            tr_q    <= bus.toggle_round;
            tm_q    <= bus.toggle_mask;
            tv_q    <= bus.toggle_value;
            state_q <= (bus.init_state & ~f0)
                     | (bus.toggle_value & f0);
            round_q <= '0;
            rr_q    <= '0;
          end
        S_RUN:
          if (!bus.abort) begin
            if (rnd_m) lfsr_q <= lfsr_nx;
            state_q <= nxt_f;
            rr_q    <= round_end ? '0 : rr_q + RIDX_W'(1);
            if (round_end) begin
              round_q <= round_q + ROUND_W'(1);
              sv_q    <= 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  assign bus.state_valid = sv_q;
  assign bus.cfg_err     = err_q;
  assign bus.state_out   = state_q;
  assign bus.round_out   = round_q;

endmodule
